// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the wave sequencer: FSM states, entry field widths, idle output values.
package wave_seq_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Entry layout, LSB first: periods[PERW-1:0], div[DIV_W-1:0], sel[SEL_W-1:0]
    localparam int unsigned SEL_W = 2;
    localparam int unsigned DIV_W = 6;
    localparam int unsigned CFG_W = SEL_W + DIV_W;

    localparam logic [SEL_W-1:0] SEL_IDLE = 2'b00;
    localparam logic [DIV_W-1:0] DIV_IDLE = 6'h3F;

endpackage

// File: rtl/wave_seq_table.sv
// Segment table: DEPTH x (8+PERW) register file, one write port, two combinational read ports.
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int PERW  = 8,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int EW    = CFG_W + PERW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [EW-1:0]    wr_data,
    input  logic [ADDRW-1:0] rd_addr,
    output logic [EW-1:0]    entry0,
    output logic [EW-1:0]    entry_rd
);

    logic [EW-1:0] mem [DEPTH];
    logic          addr_ok;

    // Widened compare so non-power-of-two depths reject out-of-range indices
    assign addr_ok = ({1'b0, wr_addr} < (ADDRW+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign entry0   = mem[0];
    assign entry_rd = mem[rd_addr];

endmodule

// File: rtl/wave_sequencer.sv
// Steps the function-generator core through a programmed segment list, switching only on period boundaries.
// Optional WAVE_SEQ_LOOP_EN adds a loop input that restarts the list instead of ending it.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int PERW  = 8,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDRW-1:0]  wr_addr,
    input  logic [8+PERW-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              period_tick,
`ifdef WAVE_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic [1:0]        sel_out,
    output logic [5:0]        div_out,
    output logic              busy,
    output logic [ADDRW-1:0]  seg_idx,
    output logic              done
);

    localparam int EW = CFG_W + PERW;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDRW-1:0]  seg_q, seg_d;
    logic [PERW-1:0]   rem_q, rem_d;
    logic              done_q, done_d;

    logic [EW-1:0]     entry0, entry_nxt;
    logic [ADDRW-1:0]  nxt;
    logic              at_last;
    logic              wrap_ok;

    assign nxt     = ADDRW'(seg_q + 1'b1);
    assign at_last = (seg_q == ADDRW'(DEPTH - 1));

`ifdef WAVE_SEQ_LOOP_EN
    assign wrap_ok = loop && (entry0[PERW-1:0] != '0);
`else
    assign wrap_ok = 1'b0;
`endif

    wave_seq_table #(
        .DEPTH (DEPTH),
        .PERW  (PERW)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (nxt),
        .entry0   (entry0),
        .entry_rd (entry_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_IDLE;
            div_q   <= DIV_IDLE;
            seg_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            div_q   <= div_d;
            seg_q   <= seg_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        div_d   = div_q;
        seg_d   = seg_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    if (entry0[PERW-1:0] != '0) begin
                        sel_d   = entry0[PERW+DIV_W +: SEL_W];
                        div_d   = entry0[PERW +: DIV_W];
                        rem_d   = entry0[PERW-1:0];
                        seg_d   = '0;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    sel_d   = SEL_IDLE;
                    div_d   = DIV_IDLE;
                    seg_d   = '0;
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (period_tick) begin
                    if (rem_q > PERW'(1)) begin
                        rem_d = rem_q - 1'b1;
                    end else if (!at_last && entry_nxt[PERW-1:0] != '0) begin
                        sel_d = entry_nxt[PERW+DIV_W +: SEL_W];
                        div_d = entry_nxt[PERW +: DIV_W];
                        rem_d = entry_nxt[PERW-1:0];
                        seg_d = nxt;
                    end else if (wrap_ok) begin
                        sel_d = entry0[PERW+DIV_W +: SEL_W];
                        div_d = entry0[PERW +: DIV_W];
                        rem_d = entry0[PERW-1:0];
                        seg_d = '0;
                    end else begin
                        sel_d   = SEL_IDLE;
                        div_d   = DIV_IDLE;
                        seg_d   = '0;
                        rem_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_out = sel_q;
    assign div_out = div_q;
    assign seg_idx = seg_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed self-checking bench for wave_sequencer (default DEPTH=8, PERW=8).
module tb_wave_sequencer;

    localparam int DEPTH = 8;
    localparam int PERW  = 8;
    localparam int ADDRW = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDRW-1:0]  wr_addr;
    logic [8+PERW-1:0] wr_data;
    logic              start;
    logic              stop;
    logic              period_tick;
`ifdef WAVE_SEQ_LOOP_EN
    logic              loop;
`endif
    logic [1:0]        sel_out;
    logic [5:0]        div_out;
    logic              busy;
    logic [ADDRW-1:0]  seg_idx;
    logic              done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wave_sequencer #(
        .DEPTH (DEPTH),
        .PERW  (PERW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .stop        (stop),
        .period_tick (period_tick),
`ifdef WAVE_SEQ_LOOP_EN
        .loop        (loop),
`endif
        .sel_out     (sel_out),
        .div_out     (div_out),
        .busy        (busy),
        .seg_idx     (seg_idx),
        .done        (done)
    );

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] s, input logic [5:0] d,
                           input logic b, input logic [ADDRW-1:0] idx, input logic dn);
        chk({tag, ".sel"},  32'(sel_out), 32'(s));
        chk({tag, ".div"},  32'(div_out), 32'(d));
        chk({tag, ".busy"}, 32'(busy),    32'(b));
        chk({tag, ".seg"},  32'(seg_idx), 32'(idx));
        chk({tag, ".done"}, 32'(done),    32'(dn));
    endtask

    task automatic wr(input int addr, input logic [1:0] s, input logic [5:0] d, input logic [PERW-1:0] p);
        wr_en   = 1'b1;
        wr_addr = ADDRW'(addr);
        wr_data = {s, d, p};
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; period_tick = 1'b0;
`ifdef WAVE_SEQ_LOOP_EN
        loop = 1'b0;
`endif
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk_out("reset", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);

        // Test 1: two-segment sequence ending at a terminator
        wr(0, 2'd1, 6'd4, 8'd2);
        wr(1, 2'd2, 6'd9, 8'd1);
        wr(2, 2'd3, 6'd7, 8'd0);
        tick();
        chk_out("t1.idle_tick", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);
        go();
        chk_out("t1.load0", 2'd1, 6'd4, 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("t1.tick1", 2'd1, 6'd4, 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("t1.tick2", 2'd2, 6'd9, 1'b1, 3'd1, 1'b0);
        tick();
        chk_out("t1.end", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b1);
        cyc();
        chk_out("t1.after", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);

        // Test 2: start with an empty first entry
        wr(0, 2'd3, 6'd5, 8'd0);
        go();
        chk_out("t2.done", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b1);
        cyc();
        chk_out("t2.after", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);

        // Test 3: every entry used, implicit end after the last index
        for (int i = 0; i < DEPTH; i++) wr(i, 2'(i % 4), 6'(i + 10), 8'd1);
        go();
        chk_out("t3.seg0", 2'd0, 6'd10, 1'b1, 3'd0, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            chk_out($sformatf("t3.seg%0d", i), 2'(i % 4), 6'(i + 10), 1'b1, 3'(i), 1'b0);
        end
        tick();
        chk_out("t3.end", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b1);

        // Test 4: stop beats a coincident tick; start+stop in IDLE does nothing
        wr(0, 2'd1, 6'd4, 8'd3);
        go();
        tick();
        chk_out("t4.run", 2'd1, 6'd4, 1'b1, 3'd0, 1'b0);
        stop = 1'b1; period_tick = 1'b1;
        cyc();
        stop = 1'b0; period_tick = 1'b0;
        chk_out("t4.stop", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);
        cyc();
        chk_out("t4.stop_nodone", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk_out("t4.startstop", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);

        // Test 5: writes to active and fetched entries during RUN
        wr(0, 2'd1, 6'd4, 8'd2);
        wr(1, 2'd2, 6'd9, 8'd1);
        go();
        wr(0, 2'd3, 6'd20, 8'd5);
        chk_out("t5.active_wr", 2'd1, 6'd4, 1'b1, 3'd0, 1'b0);
        tick();
        tick();
        chk_out("t5.fetch1", 2'd2, 6'd9, 1'b1, 3'd1, 1'b0);
        go();
        chk_out("t5.start_ign", 2'd2, 6'd9, 1'b1, 3'd1, 1'b0);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = {2'd3, 6'd40, 8'd1};
        period_tick = 1'b1;
        cyc();
        wr_en = 1'b0; period_tick = 1'b0;
        chk_out("t5.wr_fetch_old", 2'd2, 6'd12, 1'b1, 3'd2, 1'b0);
        tick();
        chk_out("t5.seg3", 2'd3, 6'd13, 1'b1, 3'd3, 1'b0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_out("t5.stop", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);
        wr(0, 2'd0, 6'd0, 8'd1);
        go();
        tick();
        tick();
        chk_out("t5.new_e2", 2'd3, 6'd40, 1'b1, 3'd2, 1'b0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

`ifdef WAVE_SEQ_LOOP_EN
        // Test 6: looping over two segments, then natural end
        wr(0, 2'd1, 6'd4, 8'd1);
        wr(1, 2'd2, 6'd9, 8'd1);
        wr(2, 2'd0, 6'd0, 8'd0);
        loop = 1'b1;
        go();
        chk_out("t6.seg0", 2'd1, 6'd4, 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("t6.seg1", 2'd2, 6'd9, 1'b1, 3'd1, 1'b0);
        tick();
        chk_out("t6.wrap", 2'd1, 6'd4, 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("t6.seg1b", 2'd2, 6'd9, 1'b1, 3'd1, 1'b0);
        loop = 1'b0;
        tick();
        chk_out("t6.end", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b1);
`endif

        // Async reset mid-RUN clears outputs and table
        wr(0, 2'd1, 6'd4, 8'd2);
        go();
        #2 rst = 1'b1;
        #1;
        chk_out("rst.async", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b0);
        cyc();
        rst = 1'b0;
        go();
        chk_out("rst.table_clr", 2'd0, 6'h3F, 1'b0, 3'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
